// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// multicycle_control_if : control/status bundle between LEGv8 FSM and datapath
// Rev 1.0
// ============================================================================
interface multicycle_control_if;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        reg2loc;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        instr_done;
    logic        fault;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_write, reg2loc,
               alu_src_a, alu_src_b, alu_op, instr_done, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_write, reg2loc,
               alu_src_a, alu_src_b, alu_op, instr_done, fault
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : Moore FSM sequencing a multi-cycle LEGv8 datapath
// Rev 1.0
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire                  clk,
    input  wire                  rst,
    multicycle_control_if.master ctrl
);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_B    = 11'b000101?????;

    // Value the wait counter holds on the last permitted waiting cycle.
    localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg2loc;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       fault;
        logic       fetch_strb;
        logic       wr_strb;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    ctrl_t      out_q;
    logic       in_wait;

    function automatic ctrl_t decode_outputs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b01;
                c.fetch_strb = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.reg2loc   = 1'b1;
                c.wr_strb   = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b010;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.reg2loc       = 1'b1;
                c.alu_op        = 3'b011;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            S_FAULT: c.fault = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // A wait state gives up only when the last permitted cycle also lacks mem_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ctrl.mem_ready)              state_d = S_DECODE;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_FAULT;
            end
            S_DECODE: begin
                unique casez (ctrl.opcode)
                    OP_LDUR, OP_STUR:                 state_d = S_MEM_ADDR;
                    OP_ADD, OP_SUB, OP_AND, OP_ORR:   state_d = S_EXEC_R;
                    OP_CBZ:                           state_d = S_BRANCH;
                    OP_B:                             state_d = S_JUMP;
                    default:                          state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: state_d = (ctrl.opcode == OP_STUR) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (ctrl.mem_ready)              state_d = S_MEM_WB;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_FAULT;
            end
            S_MEM_WR: begin
                if (ctrl.mem_ready)              state_d = S_FETCH;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_FAULT;
            end
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_EXEC_R: state_d = S_R_WB;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (in_wait && !ctrl.mem_ready)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            out_q      <= decode_outputs(state_d);
        end
    end

    // PC/IR load and store completion fire only in the cycle memory acknowledges.
    assign ctrl.pc_write      = out_q.pc_write | (out_q.fetch_strb & ctrl.mem_ready);
    assign ctrl.ir_write      = out_q.fetch_strb & ctrl.mem_ready;
    assign ctrl.instr_done    = out_q.instr_done | (out_q.wr_strb & ctrl.mem_ready);
    assign ctrl.pc_write_cond = out_q.pc_write_cond;
    assign ctrl.pc_source     = out_q.pc_source;
    assign ctrl.i_or_d        = out_q.i_or_d;
    assign ctrl.mem_read      = out_q.mem_read;
    assign ctrl.mem_write     = out_q.mem_write;
    assign ctrl.mem_to_reg    = out_q.mem_to_reg;
    assign ctrl.reg_write     = out_q.reg_write;
    assign ctrl.reg2loc       = out_q.reg2loc;
    assign ctrl.alu_src_a     = out_q.alu_src_a;
    assign ctrl.alu_src_b     = out_q.alu_src_b;
    assign ctrl.alu_op        = out_q.alu_op;
    assign ctrl.fault         = out_q.fault;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : scoreboard bench for the multicycle LEGv8 controller
// Rev 1.0
// ============================================================================
module tb_multicycle_control;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    // {pcw, pcw_cond, pc_src[2], ir_w, i_or_d, mrd, mwr, m2r, rw, r2l, src_a, src_b[2], alu_op[3], done, fault}
    localparam logic [18:0] E_IDLE    = 19'b0_0_00_0_0_0_0_0_0_0_0_00_000_0_0;
    localparam logic [18:0] E_FETCH_W = 19'b0_0_00_0_0_1_0_0_0_0_0_01_000_0_0;
    localparam logic [18:0] E_FETCH_R = 19'b1_0_00_1_0_1_0_0_0_0_0_01_000_0_0;
    localparam logic [18:0] E_DECODE  = 19'b0_0_00_0_0_0_0_0_0_0_0_11_000_0_0;
    localparam logic [18:0] E_MADDR   = 19'b0_0_00_0_0_0_0_0_0_0_1_10_000_0_0;
    localparam logic [18:0] E_MRD     = 19'b0_0_00_0_1_1_0_0_0_0_0_00_000_0_0;
    localparam logic [18:0] E_MWB     = 19'b0_0_00_0_0_0_0_1_1_0_0_00_000_1_0;
    localparam logic [18:0] E_MWR_W   = 19'b0_0_00_0_1_0_1_0_0_1_0_00_000_0_0;
    localparam logic [18:0] E_MWR_R   = 19'b0_0_00_0_1_0_1_0_0_1_0_00_000_1_0;
    localparam logic [18:0] E_EXEC    = 19'b0_0_00_0_0_0_0_0_0_0_1_00_010_0_0;
    localparam logic [18:0] E_RWB     = 19'b0_0_00_0_0_0_0_0_1_0_0_00_000_1_0;
    localparam logic [18:0] E_BR      = 19'b0_1_01_0_0_0_0_0_0_1_0_00_011_1_0;
    localparam logic [18:0] E_JMP     = 19'b1_0_10_0_0_0_0_0_0_0_0_00_000_1_0;
    localparam logic [18:0] E_FAULT   = 19'b0_0_00_0_0_0_0_0_0_0_0_00_000_0_1;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    int          checks = 0;
    int          errors = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs_a, obs_b;

    multicycle_control_if bus_a();
    multicycle_control_if bus_b();

    assign bus_a.opcode = opcode;
    assign bus_a.zero = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode = opcode;
    assign bus_b.zero = zero;
    assign bus_b.mem_ready = mem_ready;

    multicycle_control #(.MEM_TIMEOUT(15)) dut_a (.clk(clk), .rst(rst), .ctrl(bus_a));
    multicycle_control #(.MEM_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .ctrl(bus_b));

    always #5 clk = ~clk;

    assign obs_a = {bus_a.pc_write, bus_a.pc_write_cond, bus_a.pc_source, bus_a.ir_write,
                    bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write, bus_a.mem_to_reg,
                    bus_a.reg_write, bus_a.reg2loc, bus_a.alu_src_a, bus_a.alu_src_b,
                    bus_a.alu_op, bus_a.instr_done, bus_a.fault};
    assign obs_b = {bus_b.pc_write, bus_b.pc_write_cond, bus_b.pc_source, bus_b.ir_write,
                    bus_b.i_or_d, bus_b.mem_read, bus_b.mem_write, bus_b.mem_to_reg,
                    bus_b.reg_write, bus_b.reg2loc, bus_b.alu_src_a, bus_b.alu_src_b,
                    bus_b.alu_op, bus_b.instr_done, bus_b.fault};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            exp_q.push_back(E_IDLE);
            exp_q.push_back(E_IDLE);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL reset_a cyc%0d: got %b expected %b", i, obs_a, e); end
            e = exp_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL reset_b cyc%0d: got %b expected %b", i, obs_b, e); end
        end
    endtask

    task automatic test_add();
        logic [18:0] tab [5];
        logic [18:0] e;
        tab = '{E_FETCH_R, E_DECODE, E_EXEC, E_RWB, E_FETCH_R};
        mem_ready = 1'b1; opcode = OP_ADD;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_q.push_back(tab[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL add cyc%0d: got %b expected %b", i, obs_a, e); end
        end
    endtask

    task automatic test_ldur_wait();
        logic [18:0] tab [9];
        logic [8:0]  rdy;
        logic [18:0] e;
        tab = '{E_FETCH_R, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_FETCH_R};
        rdy = 9'b1_1_1_0_0_0_1_1_1;
        mem_ready = 1'b1; opcode = OP_LDUR;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_ready = rdy[8 - i];
            exp_q.push_back(tab[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL ldur cyc%0d: got %b expected %b", i, obs_a, e); end
        end
    endtask

    task automatic test_cbz();
        logic [18:0] tab [4];
        logic [18:0] e;
        tab = '{E_FETCH_R, E_DECODE, E_BR, E_FETCH_R};
        for (int z = 1; z >= 0; z--) begin
            mem_ready = 1'b1; opcode = OP_CBZ; zero = z[0];
            do_reset();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                exp_q.push_back(tab[i]);
                #2;
                e = exp_q.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL cbz z%0d cyc%0d: got %b expected %b", z, i, obs_a, e); end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_stur_and_jump();
        logic [18:0] tab_s [6];
        logic [18:0] tab_j [4];
        logic [5:0]  rdy;
        logic [18:0] e;
        tab_s = '{E_FETCH_R, E_DECODE, E_MADDR, E_MWR_W, E_MWR_R, E_FETCH_R};
        tab_j = '{E_FETCH_R, E_DECODE, E_JMP, E_FETCH_R};
        rdy = 6'b1_1_1_0_1_1;
        mem_ready = 1'b1; opcode = OP_STUR;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = rdy[5 - i];
            exp_q.push_back(tab_s[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL stur cyc%0d: got %b expected %b", i, obs_a, e); end
        end
        mem_ready = 1'b1; opcode = OP_B;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_q.push_back(tab_j[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL jump cyc%0d: got %b expected %b", i, obs_a, e); end
        end
    endtask

    task automatic test_illegal();
        logic [18:0] e;
        mem_ready = 1'b1; opcode = OP_BAD;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            exp_q.push_back((i == 0) ? E_FETCH_R : (i == 1) ? E_DECODE : E_FAULT);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL illegal cyc%0d: got %b expected %b", i, obs_a, e); end
        end
        do_reset();
        exp_q.push_back(E_IDLE);
        #2;
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL illegal_reset: got %b expected %b", obs_a, e); end
    endtask

    task automatic test_timeout();
        logic [18:0] tab1 [6];
        logic [18:0] tab2 [5];
        logic [4:0]  rdy2;
        logic [18:0] e;
        tab1 = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FAULT, E_FAULT};
        tab2 = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE};
        rdy2 = 5'b0_0_0_1_1;
        mem_ready = 1'b0; opcode = OP_ADD;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_q.push_back(tab1[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL timeout cyc%0d: got %b expected %b", i, obs_b, e); end
        end
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = rdy2[4 - i];
            exp_q.push_back(tab2[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL late_ready cyc%0d: got %b expected %b", i, obs_b, e); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [18:0] tab [4];
        logic [3:0]  rdy;
        logic [18:0] e;
        tab = '{E_FETCH_R, E_DECODE, E_MADDR, E_MWR_W};
        rdy = 4'b1_1_1_0;
        mem_ready = 1'b1; opcode = OP_STUR;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = rdy[3 - i];
            exp_q.push_back(tab[i]);
            #2;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL midwr cyc%0d: got %b expected %b", i, obs_a, e); end
        end
        #1 rst = 1'b1;
        exp_q.push_back(E_IDLE);
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL midwr_async: got %b expected %b", obs_a, e); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(E_IDLE);
        #2;
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL midwr_idle: got %b expected %b", obs_a, e); end
        @(negedge clk);
        exp_q.push_back(E_FETCH_W);
        #2;
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL midwr_fetch: got %b expected %b", obs_a, e); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz();
        test_stur_and_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
